// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: controller state encoding, active-low segment codes (bit order abcdefg), blank code.
package seg_pkg;

   typedef enum logic {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   // Active-low segment patterns, bit 6 = a ... bit 0 = g.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;

endpackage

// File: rtl/seg_dec7.sv
// Nibble to active-low seven-segment decoder; values 10-15 decode to blank.
// Latency: combinational.
// Backpressure: none.
// Ports: nib (4-bit digit value in), seg (7-bit active-low abcdefg out).
import seg_pkg::*;

module seg_dec7 (
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a one-deep word buffer and tear-free frame update.
// Latency: an/seg are registered, one cycle behind the internal digit index; each digit shown DIV cycles.
// Backpressure: in_ready = !pend_valid; a buffered word waits for the end of the current frame (or OFF).
// Ports: clk, rst (async active-high), en, in_valid/in_ready/in_data[31:0], seg[6:0], an[7:0], frame_done.
// Build option: define SEG_BLANK_LZ_EN to blank leading zero digits (digit 0 always shown).
import seg_pkg::*;

module seg_scan_ctrl #(
   parameter int DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        frame_done
);

   localparam logic [15:0] PC_LAST = 16'(DIV - 1);

   state_t      state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [31:0] shadow, pend;
   logic        pend_valid;
   logic        tick, wrap, accept, blank_lz;
   logic [3:0]  nib;
   logic [6:0]  dec_seg, seg_nxt;
   logic [7:0]  an_nxt;

   assign tick     = (state == ST_SCAN) && (pc == PC_LAST);
   assign wrap     = tick && (idx == 3'd7);
   assign in_ready = !pend_valid;
   assign accept   = in_valid && in_ready;

   // One decoder serves every digit: select the current nibble first.
   assign nib = shadow[{idx, 2'b00} +: 4];

   seg_dec7 u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

`ifdef SEG_BLANK_LZ_EN
   // A digit is a leading zero when it and every nibble above it are zero.
   assign blank_lz = (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
`else
   assign blank_lz = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      idx_nxt   = idx;
      an_nxt    = 8'hFF;
      seg_nxt   = SEG_BLANK;
      case (state)
         ST_OFF: begin
            // Hold the scan position at digit 0 so SCAN always starts fresh.
            pc_nxt  = 16'd0;
            idx_nxt = 3'd0;
            if (en) state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            an_nxt  = ~(8'b1 << idx);
            seg_nxt = blank_lz ? SEG_BLANK : dec_seg;
            if (tick) begin
               pc_nxt  = 16'd0;
               idx_nxt = idx + 3'd1;
            end else begin
               pc_nxt  = pc + 16'd1;
            end
            if (!en) state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_OFF;
         pc         <= 16'd0;
         idx        <= 3'd0;
         an         <= 8'hFF;
         seg        <= SEG_BLANK;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         idx        <= idx_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         frame_done <= wrap;
      end
   end

   // A new word lands in pend; it only reaches the displayed shadow at a
   // frame boundary while scanning, or right away when the display is off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= 32'd0;
         pend       <= 32'd0;
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend       <= in_data;
         pend_valid <= 1'b1;
      end else if (pend_valid && ((state == ST_OFF) || wrap)) begin
         shadow     <= pend;
         pend_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at DIV=4: directed scenarios plus randomized traffic against a
// cycle-count reference model (digit = elapsed scan cycles / DIV mod 8, frame every 8*DIV cycles).
// Latency/backpressure: model predicts registered outputs after each clock edge.
module tb_seg_scan_ctrl;

   localparam int DIV = 4;
   localparam logic [6:0] SEGTAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100};

   logic        clk, rst, en, in_valid, in_ready, frame_done;
   logic [31:0] in_data;
   logic [6:0]  seg;
   logic [7:0]  an;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   bit          m_on;
   int          m_t;
   logic [31:0] m_shadow, m_pend;
   bit          m_pendv;
   logic [7:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fd, exp_rdy;

   seg_scan_ctrl #(.DIV(DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] ref_seg(input logic [31:0] w, input int d);
      logic [3:0] n;
      int msnz;
      n = w[4*d +: 4];
      msnz = 0;
      for (int k = 0; k < 8; k++) if (w[4*k +: 4] != 4'd0) msnz = k;
`ifdef SEG_BLANK_LZ_EN
      if (d > msnz) return 7'h7F;
`endif
      if (n > 4'd9) return 7'h7F;
      return SEGTAB[n];
   endfunction

   task automatic model_reset();
      m_on = 0; m_t = 0; m_shadow = '0; m_pend = '0; m_pendv = 0;
   endtask

   // Advance model over the coming edge using the inputs now applied, then
   // let the edge happen and settle at posedge+1.
   task automatic step();
      int d;
      d = (m_t / DIV) % 8;
      if (m_on) begin
         exp_an  = ~(8'b1 << d);
         exp_seg = ref_seg(m_shadow, d);
      end else begin
         exp_an  = 8'hFF;
         exp_seg = 7'h7F;
      end
      exp_fd = m_on && (((m_t + 1) % (8 * DIV)) == 0);
      if (in_valid && !m_pendv) begin
         m_pend = in_data; m_pendv = 1;
      end else if (m_pendv && (!m_on || exp_fd)) begin
         m_shadow = m_pend; m_pendv = 0;
      end
      m_t  = (m_on && en) ? m_t + 1 : 0;
      m_on = en;
      exp_rdy = !m_pendv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; en = 0; in_valid = 0; in_data = '0;
      model_reset();
      #3;
      n_vec++;
      if ({an, seg, frame_done, in_ready} !== {8'hFF, 7'h7F, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_init: an=%h seg=%h fd=%b rdy=%b want FF 7F 0 1", an, seg, frame_done, in_ready);
      end
      @(negedge clk); rst = 0; en = 1;
      for (int i = 0; i < 13; i++) begin
         step();
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL reset_pre c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
      // mid-scan asynchronous reset, checked before any further edge
      in_valid = 1; in_data = 32'h1234_5678;
      step();
      in_valid = 0;
      rst = 1;
      #1;
      model_reset();
      n_vec++;
      if ({an, seg, frame_done, in_ready} !== {8'hFF, 7'h7F, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_async: an=%h seg=%h fd=%b rdy=%b want FF 7F 0 1", an, seg, frame_done, in_ready);
      end
      #1 rst = 0;
      step();
      n_vec++;
      if (an !== 8'hFF) begin
         n_bad++;
         $display("FAIL reset_first_off: an=%h want FF", an);
      end
      step();
      n_vec++;
      if ({an, seg} !== {8'hFE, 7'b0000001}) begin
         n_bad++;
         $display("FAIL reset_digit0: an=%h seg=%h want FE 01", an, seg);
      end
   endtask

   task automatic test_scan_order();
      int fd_cnt;
      en = 0;
      step(); step();
      in_valid = 1; in_data = 32'h7654_3210;
      step();
      in_valid = 0;
      step();
      en = 1;
      fd_cnt = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (frame_done === 1'b1) fd_cnt++;
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL scan_order c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
      n_vec++;
      if (fd_cnt != 2) begin
         n_bad++;
         $display("FAIL scan_fd_count: got %0d want 2", fd_cnt);
      end
   endtask

   task automatic test_tear_free();
      bit seen_rise;
      in_valid = 1; in_data = 32'h9999_9999;
      step();
      in_valid = 0;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL tear_ready_low: rdy=%b want 0", in_ready);
      end
      seen_rise = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (!seen_rise && in_ready === 1'b1) begin
            seen_rise = 1;
            n_vec++;
            if (frame_done !== 1'b1) begin
               n_bad++;
               $display("FAIL tear_release: fd=%b want 1 when rdy returns", frame_done);
            end
         end
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL tear_free c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      in_valid = 1; in_data = 32'hA1B2_C3D4;
      step();
      in_data = 32'h1357_2468;
      acc = 0;
      for (int i = 0; i < 80; i++) begin
         if (in_valid && in_ready === 1'b1) acc = 1;
         step();
         if (acc) in_valid = 0;
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL backpressure c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
      in_valid = 0;
   endtask

   task automatic test_blank_en_drop();
      in_valid = 1; in_data = 32'h3210_ABCF;
      step();
      in_valid = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL blank_scan c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
      in_valid = 1; in_data = 32'h5555_5555;
      step();
      in_valid = 0;
      en = 0;
      step();
      step();
      n_vec++;
      if (an !== 8'hFF) begin
         n_bad++;
         $display("FAIL endrop_off: an=%h want FF", an);
      end
      for (int i = 0; i < 6; i++) begin
         if (i == 3) en = 1;
         step();
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL endrop c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
   endtask

   task automatic test_lz();
      logic [31:0] words [2];
      words[0] = 32'h0000_0105;
      words[1] = 32'h0000_0000;
      for (int w = 0; w < 2; w++) begin
         en = 0;
         step(); step();
         in_valid = 1; in_data = words[w];
         step();
         in_valid = 0;
         step();
         en = 1;
         for (int i = 0; i < 36; i++) begin
            step();
            n_vec++;
            if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
               n_bad++;
               $display("FAIL lz w%0d c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", w, i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         in_valid = ($urandom_range(0, 7) == 0);
         in_data  = $urandom();
         step();
         n_vec++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_rdy}) begin
            n_bad++;
            $display("FAIL random c%0d: an=%h seg=%h fd=%b rdy=%b want %h %h %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_rdy);
         end
      end
      in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_tear_free();
      test_backpressure();
      test_blank_en_drop();
      test_lz();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
